mems_dac_spi_tx: RTL and testbench



---
 rtl/mems_dac_pkg.sv | 28 ++
 rtl/mems_spi_shifter.sv | 87 ++++++++
 rtl/mems_dac_spi_tx.sv | 134 +++++++++++++
 tb/tb_mems_dac_spi_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mems_dac_pkg.sv
// Shared types and constants for the MEMS DAC SPI transmitter.
// Command bytes match the quad DAC's 24-bit frame layout {cmd, data, 8'h00}.
package mems_dac_pkg;

   localparam int WORD_W     = 24;
   localparam int N_WORDS    = 7;
   localparam int INIT_WORDS = 2;
   localparam int ADDR_W     = 4;

   localparam logic [7:0] CMD_SOFT_RESET = 8'h28;
   // Write-and-update command; the low 3 bits select the DAC channel.
   localparam logic [7:0] CMD_WR_UPD_CH  = 8'h18;
   localparam logic [7:0] CMD_LDAC       = 8'h38;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SHIFT,
      ST_GAP,
      ST_FIN
   } state_t;

   function automatic logic [WORD_W-1:0] cmd_word(input logic [7:0] cmd,
                                                  input logic [7:0] data);
      return {cmd, data, 8'h00};
   endfunction

endpackage

// File: rtl/mems_spi_shifter.sv
// SPI frame engine: SCLK divider, half-period counter and MSB-first shift register.
// A load pulse starts one frame; frame_done flags the cycle the frame ends.
module mems_spi_shifter #(
   parameter int CLK_DIV = 4,
   parameter int WORD_W  = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [WORD_W-1:0] word,
   output logic              frame_done,
   output logic              sclk,
   output logic              sync_n,
   output logic              mosi
);

   localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [5:0]       HALF_LAST = 6'(2 * WORD_W - 1);

   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [5:0]        half_cnt_q, half_cnt_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic              sclk_q, sclk_d;
   logic              sync_n_q, sync_n_d;

   // NOTE: flops use non-blocking assignments so every register samples the
   // pre-edge value of its neighbours, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q  <= '0;
         half_cnt_q <= '0;
         shreg_q    <= '0;
         sclk_q     <= 1'b1;
         sync_n_q   <= 1'b1;
      end else begin
         div_cnt_q  <= div_cnt_d;
         half_cnt_q <= half_cnt_d;
         shreg_q    <= shreg_d;
         sclk_q     <= sclk_d;
         sync_n_q   <= sync_n_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      div_cnt_d  = div_cnt_q;
      half_cnt_d = half_cnt_q;
      shreg_d    = shreg_q;
      sclk_d     = sclk_q;
      sync_n_d   = sync_n_q;
      frame_done = 1'b0;

      if (load) begin
         shreg_d    = word;
         sync_n_d   = 1'b0;
         sclk_d     = 1'b1;
         div_cnt_d  = '0;
         half_cnt_d = '0;
      end else if (!sync_n_q) begin
         if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            if (half_cnt_q == HALF_LAST) begin
               frame_done = 1'b1;
               sync_n_d   = 1'b1;
               sclk_d     = 1'b1;
               shreg_d    = '0;
            end else begin
               half_cnt_d = half_cnt_q + 6'd1;
               // Odd half ends -> SCLK rises and the next bit is presented.
               sclk_d     = half_cnt_q[0];
               if (half_cnt_q[0]) begin
                  shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
               end
            end
         end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
         end
      end
   end

   assign sclk   = sclk_q;
   assign sync_n = sync_n_q;
   assign mosi   = shreg_q[WORD_W-1];

endmodule

// File: rtl/mems_dac_spi_tx.sv
// Sequencer that walks mems_rom and streams each command word to the quad DAC.
// The init words are only sent on the first sequence after reset.
module mems_dac_spi_tx
   import mems_dac_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [WORD_W-1:0] rom_data,
   output logic              busy,
   output logic              done,
   output logic              sclk,
   output logic              sync_n,
   output logic              mosi
);

   localparam int                GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);
   localparam logic [ADDR_W-1:0] UPD_ADDR  = ADDR_W'(INIT_WORDS);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic              fetch_cnt_q, fetch_cnt_d;
   logic              init_pend_q, init_pend_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              load;
   logic              frame_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rom_addr_q  <= '0;
         gap_cnt_q   <= '0;
         fetch_cnt_q <= 1'b0;
         init_pend_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rom_addr_q  <= rom_addr_d;
         gap_cnt_q   <= gap_cnt_d;
         fetch_cnt_q <= fetch_cnt_d;
         init_pend_q <= init_pend_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rom_addr_d  = rom_addr_q;
      gap_cnt_d   = gap_cnt_q;
      fetch_cnt_d = fetch_cnt_q;
      init_pend_d = init_pend_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      load        = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               busy_d      = 1'b1;
               rom_addr_d  = init_pend_q ? '0 : UPD_ADDR;
               fetch_cnt_d = 1'b0;
               state_d     = ST_FETCH;
            end
         end
         // Two cycles: one for the address register, one for the ROM register.
         ST_FETCH: begin
            if (fetch_cnt_q) begin
               load        = 1'b1;
               fetch_cnt_d = 1'b0;
               state_d     = ST_SHIFT;
            end else begin
               fetch_cnt_d = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (frame_done) begin
               gap_cnt_d = '0;
               state_d   = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = '0;
               if (rom_addr_q == LAST_ADDR) begin
                  done_d  = 1'b1;
                  state_d = ST_FIN;
               end else begin
                  rom_addr_d = rom_addr_q + ADDR_W'(1);
                  state_d    = ST_FETCH;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         // done is high during this cycle while busy is still set, so a start
         // arriving with done is ignored.
         ST_FIN: begin
            init_pend_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   mems_spi_shifter #(
      .CLK_DIV (CLK_DIV),
      .WORD_W  (WORD_W)
   ) u_shifter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .word       (rom_data),
      .frame_done (frame_done),
      .sclk       (sclk),
      .sync_n     (sync_n),
      .mosi       (mosi)
   );

   assign rom_addr = rom_addr_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_mems_dac_spi_tx.sv
// Bench for mems_dac_spi_tx: registered ROM model, SPI frame monitor and a
// sequence-level reference model of which words each start must send.
module tb_mems_dac_spi_tx;
   import mems_dac_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  rom_addr;
   logic [23:0] rom_data;
   logic        busy, done, sclk, sync_n, mosi;

   logic [7:0]  delta_a, delta_b, delta_c, delta_d;

   mems_dac_spi_tx #(.CLK_DIV(2), .GAP_CYCLES(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .busy     (busy),
      .done     (done),
      .sclk     (sclk),
      .sync_n   (sync_n),
      .mosi     (mosi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM holding the command words, one register of read latency.
   function automatic logic [23:0] rom_word(input logic [3:0] a);
      case (a)
         4'd0:    return cmd_word(CMD_SOFT_RESET, 8'h00);
         4'd1:    return 24'h000000;
         4'd2:    return cmd_word(CMD_WR_UPD_CH | 8'd2, delta_a);
         4'd3:    return cmd_word(CMD_WR_UPD_CH | 8'd3, delta_b);
         4'd4:    return cmd_word(CMD_WR_UPD_CH | 8'd0, delta_c);
         4'd5:    return cmd_word(CMD_WR_UPD_CH | 8'd1, delta_d);
         4'd6:    return cmd_word(CMD_LDAC, 8'h00);
         default: return 24'hDEAD00;
      endcase
   endfunction

   always @(posedge clk) rom_data <= rom_word(rom_addr);

   // ---------------- checking ----------------
   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- SPI monitor ----------------
   logic [23:0] frames[$];
   int          lens[$];
   int          nbits[$];
   int          gaps[$];
   logic [23:0] cur_word;
   int          cur_bits = 0;
   int          cur_len  = 0;
   int          gap_len  = 0;
   bit          in_frame = 0;
   logic        prev_sclk = 1'b1;
   int          done_cnt = 0;
   int          done_nobusy = 0;
   int          sclk_low_idle = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_frame = 0;
            cur_bits = 0;
            cur_len  = 0;
         end else begin
            if (!sync_n) begin
               if (!in_frame) begin
                  in_frame = 1;
                  cur_bits = 0;
                  cur_len  = 0;
                  cur_word = '0;
                  if (frames.size() > 0) gaps.push_back(gap_len);
               end
               cur_len++;
               if (prev_sclk && !sclk) begin
                  cur_word = {cur_word[22:0], mosi};
                  cur_bits++;
               end
            end else begin
               if (in_frame) begin
                  frames.push_back(cur_word);
                  lens.push_back(cur_len);
                  nbits.push_back(cur_bits);
                  in_frame = 0;
                  gap_len  = 0;
               end
               gap_len++;
               if (!sclk) sclk_low_idle++;
            end
            if (done) begin
               done_cnt++;
               if (!busy) done_nobusy++;
            end
         end
         prev_sclk = sclk;
      end
   end

   task automatic clear_mon();
      #1;
      frames.delete();
      lens.delete();
      nbits.delete();
      gaps.delete();
      done_cnt      = 0;
      done_nobusy   = 0;
      sclk_low_idle = 0;
   endtask

   // ---------------- reference model ----------------
   bit          model_init = 1;
   logic [23:0] exp_q[$];

   task automatic model_seq();
      exp_q.delete();
      if (model_init) begin
         exp_q.push_back(24'h280000);
         exp_q.push_back(24'h000000);
      end
      exp_q.push_back({8'h1A, delta_a, 8'h00});
      exp_q.push_back({8'h1B, delta_b, 8'h00});
      exp_q.push_back({8'h18, delta_c, 8'h00});
      exp_q.push_back({8'h19, delta_d, 8'h00});
      exp_q.push_back(24'h380000);
   endtask

   task automatic start_pulse();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int c = 0; c < 3000 && done_cnt == 0; c++) @(negedge clk);
      if (done_cnt == 0) check({tag, "_done_timeout"}, 0, 1);
      repeat (6) @(negedge clk);
   endtask

   task automatic compare_frames(input string tag);
      int n;
      check({tag, "_nframes"}, frames.size(), exp_q.size());
      n = (frames.size() < exp_q.size()) ? frames.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_frame%0d", tag, i), frames[i], exp_q[i]);
         check($sformatf("%s_synclow%0d", tag, i), lens[i], 96);
         check($sformatf("%s_falls%0d", tag, i), nbits[i], 24);
      end
      foreach (gaps[i]) check($sformatf("%s_gap%0d_ge2", tag, i), gaps[i] >= 2, 1);
      check({tag, "_sclk_idle_high"}, sclk_low_idle, 0);
      check({tag, "_done_once"}, done_cnt, 1);
      check({tag, "_done_with_busy"}, done_nobusy, 0);
      check({tag, "_busy_after"}, busy, 0);
      model_init = 0;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct packed {
      logic [7:0]        da, db, dc, dd;
      logic [3:0]        n;
      logic [0:6][23:0]  frm;
   } vec_t;

   vec_t vecs[3];

   initial begin
      vecs[0] = '{da: 8'h11, db: 8'h22, dc: 8'h33, dd: 8'h44, n: 4'd7,
                  frm: {24'h280000, 24'h000000, 24'h1A1100, 24'h1B2200,
                        24'h183300, 24'h194400, 24'h380000}};
      vecs[1] = '{da: 8'h11, db: 8'h22, dc: 8'h33, dd: 8'h44, n: 4'd5,
                  frm: {24'h1A1100, 24'h1B2200, 24'h183300, 24'h194400,
                        24'h380000, 24'h0, 24'h0}};
      vecs[2] = '{da: 8'h00, db: 8'hFF, dc: 8'h80, dd: 8'h01, n: 4'd5,
                  frm: {24'h1A0000, 24'h1BFF00, 24'h188000, 24'h190100,
                        24'h380000, 24'h0, 24'h0}};

      rst_n = 1'b0;
      start = 1'b0;
      {delta_a, delta_b, delta_c, delta_d} = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_sync_n", sync_n, 1);
      check("rst_sclk", sclk, 1);
      check("rst_mosi", mosi, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rom_addr", rom_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_init = 1;

      for (int v = 0; v < 3; v++) begin
         delta_a = vecs[v].da;
         delta_b = vecs[v].db;
         delta_c = vecs[v].dc;
         delta_d = vecs[v].dd;
         exp_q.delete();
         for (int i = 0; i < int'(vecs[v].n); i++) exp_q.push_back(vecs[v].frm[i]);
         clear_mon();
         start_pulse();
         wait_done($sformatf("vec%0d", v));
         compare_frames($sformatf("vec%0d", v));
      end

      // Starts while busy are neither queued nor counted.
      clear_mon();
      model_seq();
      start_pulse();
      repeat (9) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (189) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_starts");
      repeat (300) @(negedge clk);
      compare_frames("busy_starts");

      // Start coinciding with the done pulse is ignored.
      clear_mon();
      model_seq();
      start_pulse();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         #1;
         if (done) break;
      end
      check("done_seen", done, 1);
      start = 1'b1;
      check("busy_at_done", busy, 1);
      @(negedge clk);
      start = 1'b0;
      repeat (60) @(negedge clk);
      check("done_start_ignored_sync", sync_n, 1);
      compare_frames("done_start");

      // delta_c changed during the addr-2 frame lands in the addr-4 frame.
      clear_mon();
      start_pulse();
      for (int c = 0; c < 3000 && !(in_frame && frames.size() == 0 && cur_bits >= 5); c++)
         @(negedge clk);
      delta_c = 8'hA5;
      model_seq();
      wait_done("delta_change");
      if (frames.size() > 2) check("delta_change_18A500", frames[2], 24'h18A500);
      compare_frames("delta_change");

      // Reset in the middle of frame 3, bit 10.
      clear_mon();
      start_pulse();
      for (int c = 0; c < 3000 && !(frames.size() == 2 && in_frame && cur_bits == 10); c++)
         @(negedge clk);
      check("abort_point_reached", (frames.size() == 2 && cur_bits == 10), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_sync_n", sync_n, 1);
      check("abort_sclk", sclk, 1);
      check("abort_busy", busy, 0);
      check("abort_mosi", mosi, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_init = 1;
      clear_mon();
      model_seq();
      start_pulse();
      wait_done("after_abort");
      if (frames.size() > 0) check("after_abort_first", frames[0], 24'h280000);
      compare_frames("after_abort");

      // Randomized sequences against the reference model.
      for (int it = 0; it < 6; it++) begin
         delta_a = 8'($urandom);
         delta_b = 8'($urandom);
         delta_c = 8'($urandom);
         delta_d = 8'($urandom);
         repeat ($urandom_range(0, 15)) @(negedge clk);
         clear_mon();
         model_seq();
         start_pulse();
         repeat ($urandom_range(3, 400)) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         wait_done($sformatf("rand%0d", it));
         compare_frames($sformatf("rand%0d", it));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
